// File: rtl/icache_pkg.sv
// Shared definitions for the set-associative instruction cache.
// Contents: derived-width functions, FSM state enum, address-field extractor.
package icache_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      FLUSH = 2'd2
   } state_t;

   // Byte-offset width of a line (word select plus the two byte bits).
   function automatic int unsigned off_w(input int unsigned words);
      return $clog2(words) + 2;
   endfunction

   function automatic int unsigned idx_w(input int unsigned sets);
      return $clog2(sets);
   endfunction

   function automatic int unsigned tag_w(input int unsigned addr_w,
                                         input int unsigned sets,
                                         input int unsigned words);
      return addr_w - idx_w(sets) - off_w(words);
   endfunction

   // Word-select port width; at least one bit so single-word lines still elaborate.
   function automatic int unsigned sel_w(input int unsigned words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

   // Extracts 'width' bits of an address starting at bit 'lo' (width 0 yields 0).
   function automatic logic [31:0] addr_field(input logic [31:0] addr,
                                              input int unsigned lo,
                                              input int unsigned width);
      return (addr >> lo) & ((32'd1 << width) - 32'd1);
   endfunction

endpackage

// File: rtl/icache_way.sv
// One way of the cache: valid/tag/data arrays with combinational lookup.
// Ports: clock/reset (sync, active-low); lookup index/tag/word -> hit_c,
// valid_c, word_c; fill port writes a line and sets valid; clear port
// invalidates one set.
module icache_way
   import icache_pkg::*;
#(
   parameter int unsigned SETS  = 8,
   parameter int unsigned WORDS = 4,
   parameter int unsigned TAG_W = 3
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [idx_w(SETS)-1:0]  index,
   input  logic [TAG_W-1:0]        tag,
   input  logic [sel_w(WORDS)-1:0] word,
   output logic                    hit_c,
   output logic                    valid_c,
   output logic [31:0]             word_c,
   input  logic                    fill,
   input  logic [idx_w(SETS)-1:0]  fill_index,
   input  logic [TAG_W-1:0]        fill_tag,
   input  logic [32*WORDS-1:0]     fill_line,
   input  logic                    clear,
   input  logic [idx_w(SETS)-1:0]  clear_index
);

   localparam int unsigned LINE_W = 32 * WORDS;

   logic [SETS-1:0]   valid_q;
   logic [TAG_W-1:0]  tag_q  [SETS];
   logic [LINE_W-1:0] data_q [SETS];
   logic [LINE_W-1:0] line_c;

   // Valid bits: the only per-way state that reset clears.
   always_ff @(posedge clock) begin
      if (!reset) begin
         valid_q <= '0;
      end else begin
         if (clear) valid_q[clear_index] <= 1'b0;
         if (fill)  valid_q[fill_index]  <= 1'b1;
      end
   end

   // Tag and data storage, qualified by valid so no reset is needed.
   always_ff @(posedge clock) begin
      if (fill) begin
         tag_q[fill_index]  <= fill_tag;
         data_q[fill_index] <= fill_line;
      end
   end

   assign line_c  = data_q[index];
   assign valid_c = valid_q[index];
   assign hit_c   = valid_c && (tag_q[index] == tag);
   assign word_c  = line_c[{word, 5'd0} +: 32];

endmodule

// File: rtl/instruction_cache_2way.sv
// Set-associative instruction cache (1 or 2 ways, true LRU) between the fetch
// stage and a line-wide instruction memory.
// Ports: clock, reset (sync, active-low); CPU side read/address/flush ->
// readdata/busywait; memory side mem_read/mem_address -> mem_readdata/mem_busywait.
module instruction_cache_2way
   import icache_pkg::*;
#(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned SETS   = 8,
   parameter int unsigned WORDS  = 4,
   parameter int unsigned WAYS   = 2
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                read,
   input  logic [ADDR_W-1:0]                   address,
   input  logic                                flush,
   output logic [31:0]                         readdata,
   output logic                                busywait,
   output logic                                mem_read,
   output logic [ADDR_W-off_w(WORDS)-1:0]      mem_address,
   input  logic [32*WORDS-1:0]                 mem_readdata,
   input  logic                                mem_busywait
);

   localparam int unsigned OFF_W  = off_w(WORDS);
   localparam int unsigned IDX_W  = idx_w(SETS);
   localparam int unsigned TAG_W  = tag_w(ADDR_W, SETS, WORDS);
   localparam int unsigned WSEL_W = sel_w(WORDS);

   logic [TAG_W-1:0]  tag;
   logic [IDX_W-1:0]  idx;
   logic [WSEL_W-1:0] word;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  fill_idx_q, flush_cnt_q;
   logic [TAG_W-1:0]  fill_tag_q;
   logic              fill_way_q, flush_pend_q, mem_read_q;
   logic [SETS-1:0]   lru_q;
   logic [31:0]       readdata_q;

   logic [WAYS-1:0]   hit_w, valid_w;
   logic [31:0]       word_w [WAYS];
   logic              hit_c, hit_way_c, victim_c;
   logic [31:0]       hit_word_c;
   logic              miss_c, fill_c, touch_c, clear_c;

   assign tag  = TAG_W'(addr_field(32'(address), IDX_W + OFF_W, TAG_W));
   assign idx  = IDX_W'(addr_field(32'(address), OFF_W, IDX_W));
   assign word = WSEL_W'(addr_field(32'(address), 2, OFF_W - 2));

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      icache_way #(.SETS(SETS), .WORDS(WORDS), .TAG_W(TAG_W)) u_way (
         .clock       (clock),
         .reset       (reset),
         .index       (idx),
         .tag         (tag),
         .word        (word),
         .hit_c       (hit_w[w]),
         .valid_c     (valid_w[w]),
         .word_c      (word_w[w]),
         .fill        (fill_c && (fill_way_q == 1'(w))),
         .fill_index  (fill_idx_q),
         .fill_tag    (fill_tag_q),
         .fill_line   (mem_readdata),
         .clear       (clear_c),
         .clear_index (flush_cnt_q)
      );
   end

   // At most one way hits, so an OR-mux selects its word.
   always_comb begin
      hit_word_c = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (hit_w[w]) hit_word_c = hit_word_c | word_w[w];
      end
   end

   assign hit_c = |hit_w;

   // Victim: first invalid way (way 0 first), otherwise the LRU way.
   if (WAYS == 2) begin : g_two
      assign hit_way_c = hit_w[WAYS-1];
      assign victim_c  = !valid_w[0]      ? 1'b0 :
                         !valid_w[WAYS-1] ? 1'b1 : lru_q[idx];
   end else begin : g_one
      assign hit_way_c = 1'b0;
      assign victim_c  = 1'b0;
   end

   // Next-state and per-cycle strobes.
   always_comb begin
      state_d = state_q;
      miss_c  = 1'b0;
      fill_c  = 1'b0;
      touch_c = 1'b0;
      clear_c = 1'b0;
      unique case (state_q)
         IDLE: begin
            touch_c = read && hit_c;
            if (flush) begin
               state_d = FLUSH;
            end else if (read && !hit_c) begin
               miss_c  = 1'b1;
               state_d = FETCH;
            end
         end
         FETCH: begin
            if (!mem_busywait) begin
               fill_c  = 1'b1;
               state_d = (flush_pend_q || flush) ? FLUSH : IDLE;
            end
         end
         FLUSH: begin
            clear_c = 1'b1;
            if (flush_cnt_q == IDX_W'(SETS - 1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register, fill latch, flush walk, LRU and held read data.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= IDLE;
         mem_read_q   <= 1'b0;
         fill_idx_q   <= '0;
         fill_tag_q   <= '0;
         fill_way_q   <= 1'b0;
         flush_pend_q <= 1'b0;
         flush_cnt_q  <= '0;
         lru_q        <= '0;
         readdata_q   <= '0;
      end else begin
         state_q    <= state_d;
         mem_read_q <= (state_d == FETCH);
         if (miss_c) begin
            fill_idx_q <= idx;
            fill_tag_q <= tag;
            fill_way_q <= victim_c;
         end
         // A flush seen mid-fill is deferred until the fill edge.
         flush_pend_q <= (state_q == FETCH) && !fill_c && (flush_pend_q || flush);
         flush_cnt_q  <= (state_q == FLUSH) ? flush_cnt_q + 1'b1 : '0;
         if (clear_c)           lru_q[flush_cnt_q] <= 1'b0;
         else if (fill_c)       lru_q[fill_idx_q]  <= ~fill_way_q;
         else if (touch_c)      lru_q[idx]         <= ~hit_way_c;
         if (read && hit_c) readdata_q <= hit_word_c;
      end
   end

   assign readdata    = hit_c ? hit_word_c : readdata_q;
   assign busywait    = (state_q != IDLE) || (read && !hit_c);
   assign mem_read    = mem_read_q;
   assign mem_address = {fill_tag_q, fill_idx_q};

endmodule

// File: tb/tb_instruction_cache_2way.sv
// Directed bench: 2-way default build plus a 1-way build, each with a
// line memory of latency 5 whose contents encode the line address.
module tb_instruction_cache_2way;

   localparam int unsigned LAT = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset;
   logic         read0, flush0, bw0, mr0, mbw0;
   logic [9:0]   addr0;
   logic [31:0]  rd0;
   logic [5:0]   ma0;
   logic [127:0] ml0;
   logic         read1, flush1, bw1, mr1, mbw1;
   logic [9:0]   addr1;
   logic [31:0]  rd1;
   logic [5:0]   ma1;
   logic [127:0] ml1;

   int n_checks = 0;
   int n_fail   = 0;

   function automatic logic [127:0] mem_line(input logic [5:0] la);
      logic [127:0] l;
      for (int k = 0; k < 4; k++) l[k*32 +: 32] = {8'hC0, 2'b00, la, 8'h00, 8'(k)};
      return l;
   endfunction

   function automatic logic [31:0] exp_word(input logic [9:0] a);
      return {8'hC0, 2'b00, a[9:4], 8'h00, 6'd0, a[3:2]};
   endfunction

   instruction_cache_2way u_dut0 (
      .clock(clk), .reset(reset), .read(read0), .address(addr0), .flush(flush0),
      .readdata(rd0), .busywait(bw0), .mem_read(mr0), .mem_address(ma0),
      .mem_readdata(ml0), .mem_busywait(mbw0));

   instruction_cache_2way #(.WAYS(1)) u_dut1 (
      .clock(clk), .reset(reset), .read(read1), .address(addr1), .flush(flush1),
      .readdata(rd1), .busywait(bw1), .mem_read(mr1), .mem_address(ma1),
      .mem_readdata(ml1), .mem_busywait(mbw1));

   // Memory models: data valid once mem_read has been high for LAT edges.
   logic [3:0] cnt0 = '0, cnt1 = '0;
   int         fills0 = 0, fills1 = 0;
   logic [5:0] fa0 = '0, fa1 = '0;

   assign mbw0 = !(mr0 && cnt0 == 4'(LAT));
   assign mbw1 = !(mr1 && cnt1 == 4'(LAT));
   assign ml0  = mem_line(ma0);
   assign ml1  = mem_line(ma1);

   always @(posedge clk) begin
      if (!mr0) cnt0 <= '0; else if (cnt0 != 4'(LAT)) cnt0 <= cnt0 + 4'd1;
      if (!mr1) cnt1 <= '0; else if (cnt1 != 4'(LAT)) cnt1 <= cnt1 + 4'd1;
      if (mr0 && !mbw0) begin fills0 <= fills0 + 1; fa0 <= ma0; end
      if (mr1 && !mbw1) begin fills1 <= fills1 + 1; fa1 <= ma1; end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Issues a read and counts busywait cycles until the access completes.
   task automatic do_read(input bit sel, input logic [9:0] a,
                          output int stall, output logic [31:0] data);
      @(negedge clk);
      if (sel) begin read1 = 1'b1; addr1 = a; end
      else     begin read0 = 1'b1; addr0 = a; end
      #1;
      stall = 0;
      while ((sel ? bw1 : bw0) && stall < 200) begin
         stall++;
         @(negedge clk);
         #1;
      end
      data = sel ? rd1 : rd0;
   endtask

   task automatic rd_chk(input bit sel, input logic [9:0] a, input int exp_stall,
                         input string tag);
      int          stall;
      logic [31:0] data;
      do_read(sel, a, stall, data);
      check({tag, "_stall"}, 32'(stall), 32'(exp_stall));
      check({tag, "_data"}, data, exp_word(a));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n, fb;
      reset = 1'b0; read0 = 1'b0; addr0 = '0; flush0 = 1'b0;
      read1 = 1'b0; addr1 = '0; flush1 = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst_readdata", rd0, 32'h0);
      check("rst_busywait", 32'(bw0), 32'h0);
      check("rst_mem_read", 32'(mr0), 32'h0);
      check("rst_mem_addr", 32'(ma0), 32'h0);

      // Cold miss then same-line hit.
      rd_chk(1'b0, 10'h000, 7, "cold");
      check("cold_fills", 32'(fills0), 32'd1);
      check("cold_maddr", 32'(fa0), 32'h00);
      rd_chk(1'b0, 10'h00C, 0, "hit_w3");

      // Two-way conflict in set 0 with LRU eviction.
      rd_chk(1'b0, 10'h080, 7, "way1");
      check("way1_maddr", 32'(fa0), 32'h08);
      rd_chk(1'b0, 10'h000, 0, "reuse0");
      rd_chk(1'b0, 10'h100, 7, "evict");
      check("evict_maddr", 32'(fa0), 32'h10);
      rd_chk(1'b0, 10'h000, 0, "keep0");
      rd_chk(1'b0, 10'h080, 7, "evicted");
      check("conflict_fills", 32'(fills0), 32'd4);

      // Miss with read low: readdata holds the last hit word.
      @(negedge clk); read0 = 1'b0; addr0 = 10'h3F0; #1;
      check("hold_data", rd0, exp_word(10'h080));
      check("hold_bw", 32'(bw0), 32'h0);

      // Flush from IDLE.
      @(negedge clk); flush0 = 1'b1; #1;
      check("flush_pulse_bw", 32'(bw0), 32'h0);
      @(negedge clk); flush0 = 1'b0; #1;
      n = 0;
      while (bw0 && n < 200) begin n++; @(negedge clk); #1; end
      check("flush_len", 32'(n), 32'd8);
      rd_chk(1'b0, 10'h000, 7, "post_flush");

      // Flush mid-fill: fill, 8-cycle walk, then the same read misses again.
      fb = fills0;
      @(negedge clk); read0 = 1'b1; addr0 = 10'h040; #1;
      n = 0;
      while (bw0 && n < 200) begin
         n++;
         @(negedge clk);
         flush0 = (n == 2);
         #1;
      end
      flush0 = 1'b0;
      check("ff_stall", 32'(n), 32'd22);
      check("ff_data", rd0, exp_word(10'h040));
      check("ff_fills", 32'(fills0 - fb), 32'd2);

      // Reset in the third FETCH cycle aborts the fill.
      fb = fills0;
      @(negedge clk); read0 = 1'b1; addr0 = 10'h200; #1;
      repeat (3) @(negedge clk);
      reset = 1'b0; #1;
      check("rf_mr_before", 32'(mr0), 32'h1);
      @(negedge clk); reset = 1'b1; #1;
      check("rf_mem_read", 32'(mr0), 32'h0);
      check("rf_mem_addr", 32'(ma0), 32'h0);
      check("rf_busywait", 32'(bw0), 32'h1);
      n = 0;
      while (bw0 && n < 200) begin n++; @(negedge clk); #1; end
      check("rf_stall", 32'(n), 32'd7);
      check("rf_data", rd0, exp_word(10'h200));
      check("rf_fills", 32'(fills0 - fb), 32'd1);
      rd_chk(1'b0, 10'h000, 7, "after_rst");
      @(negedge clk); read0 = 1'b0;

      // Direct-mapped build: alternating same-index lines always miss.
      for (int i = 0; i < 4; i++) begin
         logic [9:0] a;
         a = (i % 2 == 1) ? 10'h080 : 10'h000;
         rd_chk(1'b1, a, 7, "w1");
         check("w1_maddr", 32'(fa1), 32'(a[9:4]));
      end
      check("w1_fills", 32'(fills1), 32'd4);
      @(negedge clk); read1 = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instruction_cache_2way.md
# instruction_cache_2way

Parametrised set-associative instruction cache sitting between the CPU fetch stage and the line-wide instruction memory. It replaces the fixed 8-line direct-mapped cache with configurable address width, set count, line size and associativity (1 or 2 ways), true LRU replacement and a synchronous flush. It has a registered miss/fill state machine and a clean busywait handshake on both the CPU side and the memory side.

## Interface
- ADDR_W, 10, CPU byte-address width
- SETS, 8, number of sets (power of 2, ≥2)
- WORDS, 4, 32-bit words per line (power of 2, ≥1)
- WAYS, 2, associativity; 1 or 2 only
- Derived: OFF_W = log2(WORDS)+2, IDX_W = log2(SETS), TAG_W = ADDR_W−IDX_W−OFF_W, LINE_W = 32·WORDS
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-low
- read  in  1  CPU fetch request
- address  in  ADDR_W  CPU byte address; bits [1:0] ignored
- flush  in  1  single-cycle pulse: invalidate all lines
- readdata  out  32  selected instruction word
- busywait  out  1  CPU stall
- mem_read  out  1  line fetch request
- mem_address  out  ADDR_W−OFF_W  line address {tag,index}
- mem_readdata  in  LINE_W  fetched line; word 0 in bits [31:0]
- mem_busywait  in  1  memory busy; low = mem_readdata valid

## Operation
- Address split: tag = address[ADDR_W−1 : IDX_W+OFF_W], index = next IDX_W bits, word = address[OFF_W−1:2].
- Per set per way: valid bit, TAG_W tag, LINE_W data. Per set: 1 LRU bit (WAYS=2 only; value = way to evict next).
- Lookup is combinational: hit_w = valid[w] && tag match; hit = OR over ways. readdata = word of the hitting way; otherwise readdata holds the last registered hit value.
- busywait = (state ≠ IDLE) || (read && !hit).
- States: IDLE, FETCH, FLUSH.
- IDLE: read && hit → LRU[index] ← other way; stay. read && !hit → latch index, tag, victim into registers; → FETCH. flush → FLUSH (flush has priority over a miss in the same cycle).
- Victim: first invalid way (way 0 preferred), else LRU[index]; WAYS=1 always way 0.
- FETCH: mem_read=1, mem_address = latched {tag,index}. On an edge with mem_busywait=0: write line, tag and valid=1 into the victim way; LRU ← other way; → IDLE. The access then hits in IDLE, so the data is presented without a second fetch.
- FLUSH: counter walks sets 0..SETS−1, clearing both valid bits and LRU of one set per cycle. After the last set → IDLE. No fetch occurs in FLUSH.
- flush arriving in FETCH is latched as pending. It is taken on the FETCH→IDLE edge: the cache goes to FLUSH instead of IDLE, and the just-filled line is cleared by the walk.
- CPU address or read changing during FETCH is ignored. The fill completes to the latched line, then IDLE re-evaluates the current request.

## Timing
- Reset (reset=0 at posedge): state=IDLE; all valid, LRU and flush-pending bits cleared in the same edge; mem_read=0, mem_address=0, readdata=0. busywait=0 unless read is asserted, which then misses.
- Reset asserted during FETCH or FLUSH aborts it. mem_read is low from the next cycle. The memory must tolerate an abandoned request.
- Hit latency: 0 cycles; data and busywait=0 in the same cycle as the request.
- Miss: busywait high from the request cycle. With memory ready N cycles after mem_read rises, the fill edge is N cycles after entering FETCH, and busywait drops one cycle after the fill edge. Total stall = N+2 cycles.
- mem_read rises the cycle after miss detection and falls the cycle after the fill edge. mem_address is stable throughout.
- Flush: busywait high for exactly SETS cycles, starting the cycle after the flush pulse.
- Memory contract: mem_busywait must be high in the first FETCH cycle unless data is already valid.

## Structure
- Shared package icache_pkg: derived-width functions (OFF_W, IDX_W, TAG_W), state enum {IDLE, FETCH, FLUSH}, address-field extract helpers.
- One sub-module, icache_way: tag/valid/data array for one way, with a combinational hit/word-select output and write/invalidate ports. It is instantiated WAYS times. The FSM, LRU and flush counter stay in the top level.

## Test plan
All scenarios use the defaults ADDR_W=10, SETS=8, WORDS=4, WAYS=2, with memory latency 5.

- Cold miss: reset, then read 0x000 → busywait high 7 cycles, one mem_read with mem_address=0x00, readdata = line word 0. Read 0x00C next → hit, 0-cycle, word 3.
- Two-way conflict: fill 0x000 and 0x080 (same index 0), re-read 0x000, then read 0x100 → 0x080 is evicted. Re-read 0x000 hits; re-read 0x080 misses.
- Flush: with lines valid, pulse flush → busywait high 8 cycles. Re-read 0x000 then misses.
- Flush during FETCH: pulse flush mid-fill → fill completes, FLUSH follows, and the next read of that address misses again.
- Reset mid-FETCH: drop reset in the 3rd FETCH cycle → mem_read=0 next cycle, state IDLE, read 0x000 misses.
- WAYS=1 build: 0x000 and 0x080 alternate → every access misses, mem_address alternating 0x00/0x08.
